stream_req_arbiter: RTL and testbench
=====================================

STREAM_REQ_ARBITER -- requirements
Module: stream_req_arbiter

Interface
REQ-001 Parameter NUM_PE, default 4, number of PE controllers sharing the filter SRAM.
REQ-002 Parameter SRAM_AW, default 12, filter SRAM address width.
REQ-003 Parameter DW, default 64, filter SRAM data width.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req_filter_valid  input  NUM_PE  per-PE filter stream request; level, held until that PE's finish pulse.
REQ-007 req_filter_k  input  NUM_PE x clog2(max_num_K)  requested output-channel group k per PE.
REQ-008 req_layer  input  NUM_PE x clog2(num_of_Conv_Layer)+1  requested conv layer per PE.
REQ-009 cfg_filter_base  input  num_of_Conv_Layer x SRAM_AW  per-layer filter base address; static during operation.
REQ-010 cfg_words_per_k  input  num_of_Conv_Layer x SRAM_AW  per-layer words per k group; 0 is legal.
REQ-011 sram_rd_en / sram_rd_addr  output  1 / SRAM_AW  filter SRAM read port; read data returns 1 cycle later.
REQ-012 sram_rd_data  input  DW  SRAM read data.
REQ-013 stream_valid / stream_data / stream_pe_id  output  1 / DW / clog2(NUM_PE)  filter word stream to the PEs, tagged with destination PE.
REQ-014 stream_filter_finish  output  NUM_PE  one-cycle per-PE completion pulse.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-017 IDLE: if any req_filter_valid bit is high, grant one PE by round-robin and latch its k and layer; go to ISSUE, or to DONE when the latched layer's cfg_words_per_k is 0.
REQ-018 Round-robin priority starts at the PE after the last granted one; after reset it starts at PE 0.
REQ-019 ISSUE: assert sram_rd_en with sram_rd_addr = base + k*words_per_k + cnt, computed at full width and truncated to SRAM_AW.
REQ-020 ISSUE: cnt runs 0 to words_per_k-1, one read per cycle; after the last read, go to DRAIN.
REQ-021 stream_valid, stream_data and stream_pe_id are registered, so each word appears exactly 1 cycle after its read; no backpressure.
REQ-022 DRAIN: lasts 1 cycle, for the final word to return; then go to DONE.
REQ-023 DONE: pulse stream_filter_finish[grant] for exactly 1 cycle; then go to IDLE; no new grant is made in this cycle.
REQ-024 A requester that drops req_filter_valid mid-burst does not abort the burst; it still completes and the finish pulse is still issued.
REQ-025 Requests arriving during a burst wait; no request is lost while it is held high.
REQ-026 Simultaneous requests are served one burst at a time in round-robin order; bursts never interleave.
REQ-027 Total latency from grant to finish pulse is words_per_k + 2 cycles; with words_per_k = 0 it is 1 cycle.

Reset
REQ-028 On rst, asynchronously enter IDLE and clear to 0: state, cnt, grant, rr pointer, sram_rd_en, stream_valid, stream_data, stream_pe_id, stream_filter_finish and busy.
REQ-029 Reset asserted mid-burst abandons the burst; no finish pulse is issued, and requesters re-request after reset.

Structure
REQ-030 Shared package holds: max_num_K, num_of_Conv_Layer, max_num_channel, the Req_Stream typedef and the FSM state enum.
REQ-031 One sub-module, rr_arbiter: a NUM_PE-wide round-robin picker that outputs a one-hot grant and an index, with the pointer updated on grant.

Verification
REQ-032 Directed scenario: PE0 requests layer 0, k=2, base=0x100, words=4 -> reads at 0x108..0x10B, four stream words tagged 0, finish[0] at cycle grant+6.
REQ-033 Directed scenario: PEs 0-3 request in the same cycle, words=2 -> bursts served in order 0,1,2,3, never overlapping, with 4 finish pulses 1 cycle each.
REQ-034 Directed scenario: PE1 served, then PE1 and PE2 request together -> PE2 is granted first.
REQ-035 Directed scenario: cfg_words_per_k=0 -> no sram_rd_en, stream_valid stays low, finish pulse 1 cycle after grant.
REQ-036 Directed scenario: rst asserted during ISSUE of a 16-word burst -> all outputs 0 immediately and no finish pulse; after release the arbiter is IDLE with the rr pointer at PE0.
REQ-037 Directed scenario: the requester drops valid mid-burst -> the remaining words still stream and finish still pulses.

Source files
------------

// File: rtl/stream_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_req_arbiter_pkg
// Description : Shared constants, request struct and FSM state encoding for
//               the filter SRAM stream arbiter.
// Revision    : 1.0
// ============================================================================
package stream_req_arbiter_pkg;

    localparam int max_num_K         = 16;
    localparam int num_of_Conv_Layer = 4;
    localparam int max_num_channel   = 64;

    localparam int K_W         = $clog2(max_num_K);
    localparam int LAYER_W     = $clog2(num_of_Conv_Layer) + 1;
    localparam int LAYER_IDX_W = $clog2(num_of_Conv_Layer);

    typedef struct packed {
        logic [K_W-1:0]     k;
        logic [LAYER_W-1:0] layer;
    } Req_Stream;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/stream_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_req_if
// Description : PE request, layer config, SRAM read port and word stream
//               bundle shared between the requesters and the arbiter.
// Revision    : 1.0
// ============================================================================
interface stream_req_if #(
    parameter int NUM_PE  = 4,
    parameter int SRAM_AW = 12,
    parameter int DW      = 64
);
    import stream_req_arbiter_pkg::*;

    localparam int PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    logic [NUM_PE-1:0]                           req_filter_valid;
    logic [NUM_PE-1:0][K_W-1:0]                  req_filter_k;
    logic [NUM_PE-1:0][LAYER_W-1:0]              req_layer;
    logic [num_of_Conv_Layer-1:0][SRAM_AW-1:0]   cfg_filter_base;
    logic [num_of_Conv_Layer-1:0][SRAM_AW-1:0]   cfg_words_per_k;
    logic                                        sram_rd_en;
    logic [SRAM_AW-1:0]                          sram_rd_addr;
    logic [DW-1:0]                               sram_rd_data;
    logic                                        stream_valid;
    logic [DW-1:0]                               stream_data;
    logic [PE_W-1:0]                             stream_pe_id;
    logic [NUM_PE-1:0]                           stream_filter_finish;
    logic                                        busy;

    modport slave (
        input  req_filter_valid, req_filter_k, req_layer,
               cfg_filter_base, cfg_words_per_k, sram_rd_data,
        output sram_rd_en, sram_rd_addr, stream_valid, stream_data,
               stream_pe_id, stream_filter_finish, busy
    );

    modport master (
        output req_filter_valid, req_filter_k, req_layer,
               cfg_filter_base, cfg_words_per_k, sram_rd_data,
        input  sram_rd_en, sram_rd_addr, stream_valid, stream_data,
               stream_pe_id, stream_filter_finish, busy
    );

endinterface
`default_nettype wire

// File: rtl/stream_req_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : NUM_PE-wide round-robin picker; priority starts one past the
//               last taken grant.
// Revision    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_PE = 4,
    parameter int PE_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_PE-1:0] req,
    input  logic              take,
    output logic [NUM_PE-1:0] onehot,
    output logic [PE_W-1:0]   idx,
    output logic              any
);

    logic [PE_W-1:0] ptr;
    int              cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        for (int i = 0; i < NUM_PE; i++) begin
            cand = (int'(ptr) + i) % NUM_PE;
            if (!any && req[cand[PE_W-1:0]]) begin
                any                  = 1'b1;
                idx                  = cand[PE_W-1:0];
                onehot[cand[PE_W-1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (take) begin
            ptr <= (idx == PE_W'(NUM_PE - 1)) ? '0 : idx + PE_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : stream_req_arbiter
// Description : Grants one PE at a time the filter SRAM and streams its
//               k-group words, tagged with the PE id, then pulses finish.
// Revision    : 1.0
// ============================================================================
module stream_req_arbiter
    import stream_req_arbiter_pkg::*;
#(
    parameter int NUM_PE  = 4,
    parameter int SRAM_AW = 12,
    parameter int DW      = 64
) (
    input  logic         clk,
    input  logic         rst,
    stream_req_if.slave  bus
);

    localparam int PE_W        = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int ADDR_FULL_W = SRAM_AW + K_W + 1;

    arb_state_e          state, state_nxt;
    logic [SRAM_AW-1:0]  cnt, cnt_nxt;
    logic [PE_W-1:0]     grant;
    logic [NUM_PE-1:0]   grant_oh;
    Req_Stream           req_lat;
    logic                stream_valid_q;
    logic [PE_W-1:0]     stream_pe_q;

    logic [NUM_PE-1:0]   arb_onehot;
    logic [PE_W-1:0]     arb_idx;
    logic                arb_any;
    logic                arb_take;
    logic [SRAM_AW-1:0]  new_words;
    logic [SRAM_AW-1:0]  cur_words;
    logic [ADDR_FULL_W-1:0] addr_full;

    // Layer codes beyond the configured table fall back to layer 0.
    function automatic logic [LAYER_IDX_W-1:0] layer_idx(input logic [LAYER_W-1:0] l);
        return (int'(l) < num_of_Conv_Layer) ? l[LAYER_IDX_W-1:0] : '0;
    endfunction

    rr_arbiter #(.NUM_PE(NUM_PE), .PE_W(PE_W)) u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_filter_valid),
        .take   (arb_take),
        .onehot (arb_onehot),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    assign arb_take  = (state == IDLE) && arb_any;
    assign new_words = bus.cfg_words_per_k[layer_idx(bus.req_layer[arb_idx])];
    assign cur_words = bus.cfg_words_per_k[layer_idx(req_lat.layer)];
    assign addr_full = ADDR_FULL_W'(bus.cfg_filter_base[layer_idx(req_lat.layer)])
                     + ADDR_FULL_W'(req_lat.k) * ADDR_FULL_W'(cur_words)
                     + ADDR_FULL_W'(cnt);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (arb_any) state_nxt = (new_words == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (cnt == cur_words - SRAM_AW'(1)) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + SRAM_AW'(1);
                end
            end
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            grant          <= '0;
            grant_oh       <= '0;
            req_lat        <= '0;
            stream_valid_q <= 1'b0;
            stream_pe_q    <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            stream_valid_q <= (state == ISSUE);
            if (arb_take) begin
                grant    <= arb_idx;
                grant_oh <= arb_onehot;
                req_lat  <= '{k: bus.req_filter_k[arb_idx], layer: bus.req_layer[arb_idx]};
            end
            if (state == ISSUE) stream_pe_q <= grant;
        end
    end

    assign bus.sram_rd_en   = (state == ISSUE);
    assign bus.sram_rd_addr = (state == ISSUE) ? addr_full[SRAM_AW-1:0] : '0;
    // SRAM data already lags its read by one cycle, so it is forwarded under the registered valid.
    assign bus.stream_valid         = stream_valid_q;
    assign bus.stream_data          = stream_valid_q ? bus.sram_rd_data : {DW{1'b0}};
    assign bus.stream_pe_id         = stream_pe_q;
    assign bus.stream_filter_finish = (state == DONE) ? grant_oh : '0;
    assign bus.busy                 = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_stream_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_req_arbiter
// Description : Scoreboard bench: stimulus queues expected reads, words and
//               finish pulses with their cycle; a monitor pops and compares.
// Revision    : 1.0
// ============================================================================
module tb_stream_req_arbiter;
    import stream_req_arbiter_pkg::*;

    localparam int NUM_PE  = 4;
    localparam int SRAM_AW = 12;
    localparam int DW      = 64;

    typedef struct {
        int          cyc;
        logic [63:0] val;
        int          pe;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   drop_at [NUM_PE];
    int   tb_base [4] = '{'h100, 'h200, 'h300, 'h400};
    int   tb_words[4] = '{4, 2, 0, 16};
    ent_t rd_q[$];
    ent_t wd_q[$];
    ent_t fn_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stream_req_if #(.NUM_PE(NUM_PE), .SRAM_AW(SRAM_AW), .DW(DW)) bus ();

    stream_req_arbiter #(.NUM_PE(NUM_PE), .SRAM_AW(SRAM_AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [63:0] mem_word(input logic [11:0] a);
        return {20'hC0DE5, a, 20'hA5A5A, a};
    endfunction

    always @(posedge clk) if (bus.sram_rd_en) bus.sram_rd_data <= mem_word(bus.sram_rd_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        ent_t e;
        if (bus.sram_rd_en) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                e = rd_q.pop_front();
                chk("rd_addr", 64'(bus.sram_rd_addr), e.val);
                chk("rd_cyc", 64'(cyc), 64'(e.cyc));
            end
        end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
            e = rd_q.pop_front();
            chk("rd_missing", 0, 1);
        end
        if (bus.stream_valid) begin
            if (wd_q.size() == 0) chk("word_unexpected", 1, 0);
            else begin
                e = wd_q.pop_front();
                chk("word_data", bus.stream_data, e.val);
                chk("word_pe", 64'(bus.stream_pe_id), 64'(e.pe));
                chk("word_cyc", 64'(cyc), 64'(e.cyc));
            end
        end else if (wd_q.size() > 0 && wd_q[0].cyc <= cyc) begin
            e = wd_q.pop_front();
            chk("word_missing", 0, 1);
        end
        if (bus.stream_filter_finish != '0) begin
            if (fn_q.size() == 0) chk("finish_unexpected", 64'(bus.stream_filter_finish), 0);
            else begin
                e = fn_q.pop_front();
                chk("finish_vec", 64'(bus.stream_filter_finish), e.val);
                chk("finish_cyc", 64'(cyc), 64'(e.cyc));
            end
        end else if (fn_q.size() > 0 && fn_q[0].cyc <= cyc) begin
            e = fn_q.pop_front();
            chk("finish_missing", 0, e.val);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        for (int p = 0; p < NUM_PE; p++) begin
            if (drop_at[p] == cyc) begin
                bus.req_filter_valid[p] = 1'b0;
                drop_at[p] = -1;
            end
        end
    endtask

    task automatic request(input int pe, input int layer, input int k);
        bus.req_filter_k[pe]     = K_W'(k);
        bus.req_layer[pe]        = LAYER_W'(layer);
        bus.req_filter_valid[pe] = 1'b1;
    endtask

    task automatic expect_burst(input int pe, input int layer, input int k, input int g, output int fin);
        int w;
        logic [11:0] a;
        w = tb_words[layer];
        for (int i = 0; i < w; i++) begin
            a = 12'((tb_base[layer] + k * w + i) & 'hFFF);
            rd_q.push_back('{g + 1 + i, 64'(a), pe});
            wd_q.push_back('{g + 2 + i, mem_word(a), pe});
        end
        fin = (w == 0) ? g + 1 : g + w + 2;
        fn_q.push_back('{fin, 64'(1) << pe, pe});
        drop_at[pe] = fin;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((rd_q.size() + wd_q.size() + fn_q.size() != 0 || bus.req_filter_valid != '0 || bus.busy)
               && n < 300) begin
            tick();
            n++;
        end
        chk("quiet_timeout", 64'(n >= 300), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd_en"},   64'(bus.sram_rd_en), 0);
        chk({tag, "_svalid"},  64'(bus.stream_valid), 0);
        chk({tag, "_sdata"},   bus.stream_data, 0);
        chk({tag, "_pe_id"},   64'(bus.stream_pe_id), 0);
        chk({tag, "_finish"},  64'(bus.stream_filter_finish), 0);
        chk({tag, "_busy"},    64'(bus.busy), 0);
    endtask

    initial begin
        int c, f, f2;
        for (int p = 0; p < NUM_PE; p++) drop_at[p] = -1;
        bus.req_filter_valid = '0;
        bus.req_filter_k     = '0;
        bus.req_layer        = '0;
        bus.sram_rd_data     = '0;
        for (int l = 0; l < 4; l++) begin
            bus.cfg_filter_base[l] = SRAM_AW'(tb_base[l]);
            bus.cfg_words_per_k[l] = SRAM_AW'(tb_words[l]);
        end
        rst = 1'b1;
        tick();
        tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Single PE0 burst: layer 0, k=2 -> 0x108..0x10B, finish at grant+6.
        c = cyc;
        request(0, 0, 2);
        expect_burst(0, 0, 2, c, f);
        tick(); tick(); tick();
        chk("busy_mid_burst", 64'(bus.busy), 1);
        wait_quiet();
        chk("busy_after", 64'(bus.busy), 0);

        // All four PEs at once from a fresh pointer: served 0,1,2,3 back to back.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        c = cyc;
        for (int p = 0; p < NUM_PE; p++) request(p, 1, p);
        for (int p = 0; p < NUM_PE; p++) begin
            expect_burst(p, 1, p, c, f);
            c = f + 1;
        end
        wait_quiet();

        // PE1 served, then PE1 and PE2 together: PE2 wins.
        c = cyc;
        request(1, 1, 1);
        expect_burst(1, 1, 1, c, f);
        wait_quiet();
        tick();
        c = cyc;
        request(1, 1, 1);
        request(2, 1, 2);
        expect_burst(2, 1, 2, c, f);
        expect_burst(1, 1, 1, f + 1, f2);
        wait_quiet();

        // Zero-word layer: no reads, finish one cycle after grant.
        c = cyc;
        request(3, 2, 5);
        expect_burst(3, 2, 5, c, f);
        wait_quiet();

        // Requester drops valid mid-burst; burst and finish still complete.
        c = cyc;
        request(2, 0, 1);
        expect_burst(2, 0, 1, c, f);
        drop_at[2] = c + 2;
        wait_quiet();

        // Reset during a 16-word burst from PE0 abandons it.
        c = cyc;
        request(0, 3, 0);
        for (int i = 0; i < 5; i++) rd_q.push_back('{c + 1 + i, 64'('h400 + i), 0});
        for (int i = 0; i < 4; i++) wd_q.push_back('{c + 2 + i, mem_word(12'('h400 + i)), 0});
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        bus.req_filter_valid = '0;
        for (int p = 0; p < NUM_PE; p++) drop_at[p] = -1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("post_rst_busy", 64'(bus.busy), 0);
        // Pointer must be back at PE0 even though PE0 was the last grant.
        c = cyc;
        request(0, 1, 3);
        request(1, 1, 4);
        expect_burst(0, 1, 3, c, f);
        expect_burst(1, 1, 4, f + 1, f2);
        wait_quiet();

        tick(); tick();
        chk("rd_q_left", 64'(rd_q.size()), 0);
        chk("wd_q_left", 64'(wd_q.size()), 0);
        chk("fn_q_left", 64'(fn_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
